power_mode_ctrl: RTL and testbench
==================================

POWER_MODE_CTRL -- requirements
Module: power_mode_ctrl

Interface
REQ-001 The block SHALL have exactly one clock, sys_clk, and one reset, rst_n, which is asynchronous and active-low.
REQ-002 Parameter TICK_DIV, default 100000: sys_clk cycles per internal 1 ms tick.
REQ-003 Parameter HOLD_TICKS, default 1000: ticks power_on must be held to start the engine.
REQ-004 Parameter IDLE_TICKS, default 10000: ticks without activity in manual mode before auto power-off.
REQ-005 Parameter MODE_TICKS, default 20: ticks mode switches must be stable before a mode change commits.
REQ-006 sys_clk  in  1  system clock.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 power_on  in  1  raw power-on button, asynchronous, active-high.
REQ-009 power_off  in  1  raw power-off button, asynchronous, active-high.
REQ-010 mode_signal1, mode_signal2  in  1 each  raw mode switches.
REQ-011 activity  in  1  level; high while any move/turn/place/destroy command is asserted.
REQ-012 engine_on  out  1  high only in state ON.
REQ-013 state  out  2  00 OFF, 01 ARMING, 10 ON, 11 RELEASE.
REQ-014 mode  out  2  00 none, 01 manual, 10 semi-auto, 11 auto; 00 whenever engine_on is low.
REQ-015 hold_progress  out  10  ARMING tick count, saturating at 1023; 0 outside ARMING.

Function
REQ-016 All raw inputs SHALL pass through a 2-flop synchronizer; "sync" below means the second-flop output (2-cycle latency).
REQ-017 Tick SHALL be a 1-cycle pulse every TICK_DIV cycles from a free-running counter cleared by reset; first tick at cycle TICK_DIV after reset release.
REQ-018 OFF: sync power_on high and sync power_off low -> ARMING with hold counter cleared.
REQ-019 ARMING: hold counter +1 on each tick; sync power_on low -> OFF next cycle; sync power_off high -> OFF (priority over all).
REQ-020 ARMING: hold counter reaching HOLD_TICKS -> ON on the next cycle; mode is committed from the current sync switches in that same cycle.
REQ-021 Mode decode: {s1,s2} = 1x -> auto, 01 -> semi-auto, 00 -> manual.
REQ-022 ON: a decoded switch value different from mode SHALL commit only after MODE_TICKS consecutive ticks of stability; any change in the switches restarts the count.
REQ-023 ON: sync power_off high -> RELEASE next cycle; engine_on and mode SHALL drop in that same cycle.
REQ-024 ON, manual mode: idle counter +1 per tick while sync activity is low, cleared in any cycle it is high; reaching IDLE_TICKS -> RELEASE.
REQ-025 The idle counter SHALL be held at 0 in semi-auto and auto modes and on every mode commit.
REQ-026 RELEASE: -> OFF once sync power_on and sync power_off are both low; a held power_on SHALL never re-arm without a release.
REQ-027 Simultaneous sync power_on and power_off SHALL be treated as power_off in every state.
REQ-028 All counters SHALL be wide enough for their parameter and SHALL saturate, never wrap.
REQ-029 Outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-030 rst_n low SHALL immediately force state=OFF, engine_on=0, mode=00, hold_progress=0, clear all counters and synchronizers, and clear the tick divider.
REQ-031 Reset asserted mid-ARMING or mid-ON SHALL abort with no restart after release until a fresh power_on hold.
REQ-032 Reset deassertion SHALL be synchronized to sys_clk before internal use.

Verification (TICK_DIV=4, HOLD_TICKS=10, IDLE_TICKS=20, MODE_TICKS=3)
REQ-033 Hold power_on 50 cycles, switches 01 -> ARMING, ON after 10 ticks, engine_on=1, mode=10.
REQ-034 Hold power_on 8 ticks then release -> OFF, hold_progress=0, engine_on never 1.
REQ-035 In ON, switches 00: hold 2 ticks then back to 01 -> mode stays 10; hold 00 for 3 ticks -> mode=01.
REQ-036 Manual mode, activity low 20 ticks -> RELEASE, engine_on=0; pulsing activity every 10 ticks -> stays ON.
REQ-037 power_on held through ON, press power_off -> RELEASE; still holding power_on -> stays RELEASE, OFF only after both released.
REQ-038 Assert rst_n low mid-ARMING at tick 5 -> all outputs 0 immediately; release with power_on still high -> ARMING restarts from 0.

Source files
------------

// File: rtl/power_mode_ctrl_if.sv
// Button/switch inputs and status outputs of the engine power controller.
interface power_mode_ctrl_if;
    logic       power_on;
    logic       power_off;
    logic       mode_signal1;
    logic       mode_signal2;
    logic       activity;
    logic       engine_on;
    logic [1:0] state;
    logic [1:0] mode;
    logic [9:0] hold_progress;

    modport master (
        output power_on, power_off, mode_signal1, mode_signal2, activity,
        input  engine_on, state, mode, hold_progress
    );

    modport slave (
        input  power_on, power_off, mode_signal1, mode_signal2, activity,
        output engine_on, state, mode, hold_progress
    );
endinterface

// File: rtl/power_mode_ctrl.sv
// Engine power FSM: hold-to-arm, debounced mode select, manual idle-off.
module power_mode_ctrl #(
    parameter int TICK_DIV   = 100000,
    parameter int HOLD_TICKS = 1000,
    parameter int IDLE_TICKS = 10000,
    parameter int MODE_TICKS = 20
) (
    input  logic             sys_clk,
    input  logic             rst_n,
    power_mode_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        S_OFF = 2'b00,
        S_ARM = 2'b01,
        S_ON  = 2'b10,
        S_REL = 2'b11
    } state_t;

    localparam logic [1:0] M_NONE = 2'b00;
    localparam logic [1:0] M_MAN  = 2'b01;
    localparam logic [1:0] M_SEMI = 2'b10;
    localparam logic [1:0] M_AUTO = 2'b11;

    localparam int DW = $clog2(TICK_DIV + 1);
    localparam int HC = $clog2(HOLD_TICKS + 1);
    localparam int HW = (HC > 10) ? HC : 10;
    localparam int IW = $clog2(IDLE_TICKS + 1);
    localparam int MW = $clog2(MODE_TICKS + 1);

    localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_TICKS);
    localparam logic [HW-1:0] PROG_MAX = HW'(1023);
    localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_TICKS);
    localparam logic [MW-1:0] MODE_MAX = MW'(MODE_TICKS);

    logic [1:0]    r_rst;
    logic          w_rst_n;
    logic [4:0]    r_meta;
    logic [4:0]    r_sync;
    logic [DW-1:0] r_div;
    logic          w_tick;
    state_t        r_state;
    state_t        w_state_nx;
    logic [HW-1:0] r_hold;
    logic [HW-1:0] w_hold_nx;
    logic [IW-1:0] r_idle;
    logic [IW-1:0] w_idle_nx;
    logic [MW-1:0] r_mcnt;
    logic [MW-1:0] w_mcnt_nx;
    logic [1:0]    r_mode;
    logic [1:0]    w_mode_nx;
    logic [1:0]    r_prev_dec;
    logic [1:0]    w_dec;
    logic          w_pon;
    logic          w_poff;
    logic          w_act;
    logic          w_commit;

    // Reset asserts at once but releases only on a clock edge.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) r_rst <= 2'b00;
        else        r_rst <= {r_rst[0], 1'b1};
    end

    assign w_rst_n = r_rst[1];

    always_ff @(posedge sys_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= {bus.power_on, bus.power_off, bus.mode_signal1,
                       bus.mode_signal2, bus.activity};
            r_sync <= r_meta;
        end
    end

    assign w_pon  = r_sync[4];
    assign w_poff = r_sync[3];
    assign w_act  = r_sync[0];

    always_comb begin
        priority case (1'b1)
            r_sync[2]: w_dec = M_AUTO;
            r_sync[1]: w_dec = M_SEMI;
            default:   w_dec = M_MAN;
        endcase
    end

    assign w_tick = (r_div == DIV_LAST);

    always_ff @(posedge sys_clk or negedge w_rst_n) begin
        if (!w_rst_n)    r_div <= '0;
        else if (w_tick) r_div <= '0;
        else             r_div <= r_div + 1'b1;
    end

    always_ff @(posedge sys_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state    <= S_OFF;
            r_hold     <= '0;
            r_idle     <= '0;
            r_mcnt     <= '0;
            r_mode     <= M_NONE;
            r_prev_dec <= M_NONE;
        end else begin
            r_state    <= w_state_nx;
            r_hold     <= w_hold_nx;
            r_idle     <= w_idle_nx;
            r_mcnt     <= w_mcnt_nx;
            r_mode     <= w_mode_nx;
            r_prev_dec <= w_dec;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_hold_nx  = '0;
        w_idle_nx  = '0;
        w_mcnt_nx  = '0;
        w_mode_nx  = r_mode;
        w_commit   = 1'b0;
        unique case (r_state)
            S_OFF: begin
                w_mode_nx = M_NONE;
                if (w_pon && !w_poff) w_state_nx = S_ARM;
            end
            S_ARM: begin
                w_hold_nx = r_hold;
                if (w_poff || !w_pon) begin
                    w_state_nx = S_OFF;
                    w_hold_nx  = '0;
                end else if (r_hold >= HOLD_MAX) begin
                    w_state_nx = S_ON;
                    w_hold_nx  = '0;
                    w_mode_nx  = w_dec;
                end else if (w_tick) begin
                    w_hold_nx = r_hold + 1'b1;
                end
            end
            S_ON: begin
                w_idle_nx = r_idle;
                w_mcnt_nx = r_mcnt;
                if (w_poff) begin
                    w_state_nx = S_REL;
                    w_mode_nx  = M_NONE;
                    w_idle_nx  = '0;
                    w_mcnt_nx  = '0;
                end else if (r_mode == M_MAN && r_idle >= IDLE_MAX) begin
                    w_state_nx = S_REL;
                    w_mode_nx  = M_NONE;
                    w_idle_nx  = '0;
                    w_mcnt_nx  = '0;
                end else begin
                    // Any switch movement restarts the stability count.
                    if (w_dec == r_mode || w_dec != r_prev_dec) begin
                        w_mcnt_nx = '0;
                    end else if (r_mcnt >= MODE_MAX) begin
                        w_commit  = 1'b1;
                        w_mode_nx = w_dec;
                        w_mcnt_nx = '0;
                    end else if (w_tick) begin
                        w_mcnt_nx = r_mcnt + 1'b1;
                    end
                    if (r_mode != M_MAN || w_commit || w_act) begin
                        w_idle_nx = '0;
                    end else if (w_tick && r_idle < IDLE_MAX) begin
                        w_idle_nx = r_idle + 1'b1;
                    end
                end
            end
            S_REL: begin
                w_mode_nx = M_NONE;
                if (!w_pon && !w_poff) w_state_nx = S_OFF;
            end
        endcase
    end

    assign bus.engine_on     = (r_state == S_ON);
    assign bus.state         = r_state;
    assign bus.mode          = r_mode;
    assign bus.hold_progress = (r_hold > PROG_MAX) ? 10'd1023 : r_hold[9:0];
endmodule

// File: tb/tb_power_mode_ctrl.sv
// Random scenario bench for power_mode_ctrl with an event-level scoreboard.
module tb_power_mode_ctrl;
    localparam int TD = 4;
    localparam int HT = 10;
    localparam int IT = 20;
    localparam int MT = 3;

    localparam logic [1:0] S_OFF = 2'd0;
    localparam logic [1:0] S_ARM = 2'd1;
    localparam logic [1:0] S_ON  = 2'd2;
    localparam logic [1:0] S_REL = 2'd3;

    typedef struct {
        logic [1:0] st;
        logic [1:0] md;
        int         hlo;
        int         hhi;
    } exp_t;

    logic sys_clk = 1'b0;
    logic rst_n;

    power_mode_ctrl_if bus ();

    power_mode_ctrl #(
        .TICK_DIV  (TD),
        .HOLD_TICKS(HT),
        .IDLE_TICKS(IT),
        .MODE_TICKS(MT)
    ) dut (
        .sys_clk(sys_clk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    always #5 sys_clk = ~sys_clk;

    exp_t       q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [1:0] m_st;
    logic [1:0] m_md;
    logic [1:0] sw;

    task automatic chk(input string nm, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", nm, act, req);
        end
    endtask

    task automatic chk_rng(input string nm, input int act,
                           input int lo, input int hi);
        n_cmp++;
        if (act < lo || act > hi) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d..%0d", nm, act, lo, hi);
        end
    endtask

    // Operator-visible meaning of the switches: s1 wins, then s2.
    function automatic logic [1:0] dec(input logic [1:0] s);
        if (s[1]) return 2'b11;
        if (s[0]) return 2'b10;
        return 2'b01;
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic expect_ev(input logic [1:0] st, input logic [1:0] md,
                             input int lo, input int hi);
        exp_t e;
        e.st  = st;
        e.md  = md;
        e.hlo = lo;
        e.hhi = hi;
        q.push_back(e);
        m_st = st;
        m_md = md;
    endtask

    task automatic drain(input int budget, input string nm);
        int k;
        k = 0;
        while (q.size() != 0 && k < budget) begin
            step(1);
            k++;
        end
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain_%s: %0d events pending, required 0",
                     nm, q.size());
            q.delete();
        end
    endtask

    task automatic set_sw(input logic [1:0] s);
        sw               = s;
        bus.mode_signal1 = s[1];
        bus.mode_signal2 = s[0];
    endtask

    task automatic pick_other(output logic [1:0] s);
        s = 2'($urandom_range(0, 3));
        while (dec(s) == m_md) s = 2'($urandom_range(0, 3));
    endtask

    task automatic zero_checks(input string nm);
        chk({nm, "_state"},  int'(bus.state), 0);
        chk({nm, "_engine"}, int'(bus.engine_on), 0);
        chk({nm, "_mode"},   int'(bus.mode), 0);
        chk({nm, "_hold"},   int'(bus.hold_progress), 0);
    endtask

    task automatic op_arm(input int s);
        if (s < 0) set_sw(2'($urandom_range(0, 3)));
        else       set_sw(2'(s));
        step(3);
        bus.power_on = 1'b1;
        expect_ev(S_ARM, 2'b00, 0, 0);
        expect_ev(S_ON, dec(sw), HT, HT);
        step(HT * TD + int'($urandom_range(10, 20)));
        bus.power_on = 1'b0;
        drain(60, "arm");
    endtask

    task automatic op_abort(input int k);
        bus.power_on = 1'b1;
        expect_ev(S_ARM, 2'b00, 0, 0);
        expect_ev(S_OFF, 2'b00, k - 1, k);
        step(k * TD);
        bus.power_on = 1'b0;
        drain(20, "abort");
    endtask

    task automatic op_both_off();
        bus.power_on  = 1'b1;
        bus.power_off = 1'b1;
        step(int'($urandom_range(20, 60)));
        bus.power_on  = 1'b0;
        bus.power_off = 1'b0;
        step(5);
    endtask

    task automatic op_reset_arm();
        bus.power_on = 1'b1;
        expect_ev(S_ARM, 2'b00, 0, 0);
        step(5 * TD);
        expect_ev(S_OFF, 2'b00, 3, 6);
        rst_n = 1'b0;
        #1;
        zero_checks("rst_mid_arm");
        step(3);
        expect_ev(S_ARM, 2'b00, 0, 0);
        expect_ev(S_ON, dec(sw), HT, HT);
        rst_n = 1'b1;
        step(HT * TD + 30);
        bus.power_on = 1'b0;
        drain(60, "rearm");
    endtask

    task automatic op_reset_on();
        expect_ev(S_OFF, 2'b00, 0, 0);
        rst_n = 1'b0;
        #1;
        zero_checks("rst_mid_on");
        step(3);
        rst_n = 1'b1;
        step(10);
        drain(5, "rst_on");
    endtask

    task automatic op_glitch(input int s);
        logic [1:0] keep;
        logic [1:0] s2;
        keep = sw;
        if (s < 0) pick_other(s2);
        else       s2 = 2'(s);
        set_sw(s2);
        step(int'($urandom_range(1, 2 * TD)));
        set_sw(keep);
        step(20);
    endtask

    task automatic op_commit(input int s);
        logic [1:0] s2;
        if (s < 0) pick_other(s2);
        else       s2 = 2'(s);
        set_sw(s2);
        expect_ev(S_ON, dec(s2), 0, 0);
        step(int'($urandom_range(24, 30)));
        drain(20, "commit");
    endtask

    task automatic op_stay();
        bus.activity = 1'b0;
        repeat (3) begin
            step(10 * TD - 1);
            bus.activity = 1'b1;
            step(1);
            bus.activity = 1'b0;
        end
        step(10 * TD);
        bus.activity = 1'b1;
        step(4);
    endtask

    task automatic op_idle();
        int k;
        if (m_md != 2'b01) op_commit(0);
        bus.activity = 1'b0;
        expect_ev(S_REL, 2'b00, 0, 0);
        expect_ev(S_OFF, 2'b00, 0, 0);
        k = 0;
        while (q.size() == 2 && k < IT * TD + 40) begin
            step(1);
            k++;
        end
        chk_rng("idle_latency", k, IT * TD - TD, IT * TD + 2 * TD);
        drain(20, "idle");
        bus.activity = 1'b1;
        step(4);
    endtask

    task automatic op_poff(input int hold);
        bus.power_on  = hold[0];
        bus.power_off = 1'b1;
        expect_ev(S_REL, 2'b00, 0, 0);
        step(int'($urandom_range(5, 15)));
        if (hold != 0) begin
            bus.power_off = 1'b0;
            step(int'($urandom_range(10, 30)));
            expect_ev(S_OFF, 2'b00, 0, 0);
            bus.power_on = 1'b0;
        end else begin
            expect_ev(S_OFF, 2'b00, 0, 0);
            bus.power_off = 1'b0;
        end
        drain(20, "poff");
    endtask

    initial begin
        logic [1:0] p_st;
        logic [1:0] p_md;
        int         p_hold;
        exp_t       e;
        p_st   = 2'd0;
        p_md   = 2'd0;
        p_hold = 0;
        forever begin
            @(negedge sys_clk);
            chk("engine_vs_state", int'(bus.engine_on),
                int'(bus.state == S_ON));
            if (bus.state != S_ON)
                chk("mode_not_on", int'(bus.mode), 0);
            else
                chk("mode_on_valid", int'(bus.mode != 2'd0), 1);
            if (bus.state != S_ARM)
                chk("hold_outside_arm", int'(bus.hold_progress), 0);
            if (bus.state != p_st || bus.mode != p_md) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_change: state %0d mode %0d, %s",
                             bus.state, bus.mode, "required no change");
                end else begin
                    e = q.pop_front();
                    chk("ev_state", int'(bus.state), int'(e.st));
                    chk("ev_mode", int'(bus.mode), int'(e.md));
                    chk_rng("ev_prev_hold", p_hold, e.hlo, e.hhi);
                end
            end
            p_st   = bus.state;
            p_md   = bus.mode;
            p_hold = int'(bus.hold_progress);
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int r;
        bus.power_on  = 1'b0;
        bus.power_off = 1'b0;
        bus.activity  = 1'b1;
        set_sw(2'b00);
        m_st  = S_OFF;
        m_md  = 2'b00;
        rst_n = 1'b1;
        #2;
        rst_n = 1'b0;
        step(4);
        zero_checks("reset");
        rst_n = 1'b1;
        step(6);

        op_arm(1);
        op_glitch(0);
        op_commit(0);
        op_stay();
        op_idle();
        op_abort(8);
        op_both_off();
        op_reset_arm();
        op_poff(1);

        for (int i = 0; i < 30; i++) begin
            r = int'($urandom_range(0, 9));
            if (m_st == S_OFF) begin
                if (r < 6)       op_arm(-1);
                else if (r < 8)  op_abort(int'($urandom_range(2, 7)));
                else if (r == 8) op_reset_arm();
                else             op_both_off();
            end else begin
                case (r)
                    0, 1, 9: op_glitch(-1);
                    2, 3:    op_commit(-1);
                    4:       op_idle();
                    5:       op_stay();
                    6, 7:    op_poff(int'($urandom_range(0, 1)));
                    default: op_reset_on();
                endcase
            end
        end

        step(20);
        chk("queue_empty", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
